// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: once-per-frame position controller for the circular
// player sprite in the 320x240 half-resolution scene.
//   - Keys are synchronised through 2-FF chains. A one-cycle frame tick is
//     derived from the falling edge of vsync.
//   - Walking is horizontal. A GROUND/RISE/FALL state machine handles jumps
//     and gravity.
//   - Optional feature macro: PLAYER_DBLJUMP_EN. When it is defined, one
//     extra jump is allowed while airborne, and only on a fresh press.
// Handshake: none. All state moves only on cycles where tick_r is high.
// Hierarchical debug: the FSM state is held in 'state'. The frame tick is
// held in 'tick_r'.
module player_motion_ctrl #(
  parameter int X_INIT   = 70,
  parameter int Y_INIT   = 180,
  parameter int X_MIN    = 30,
  parameter int X_MAX    = 290,
  parameter int Y_MIN    = 30,
  parameter int Y_GROUND = 180,
  parameter int STEP     = 2,
  parameter int JUMP_V   = 8,
  parameter int V_MAX    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_jump,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        on_ground,
  output logic [15:0] frame_cnt
);

  localparam logic [9:0] X_INIT_V   = 10'(X_INIT);
  localparam logic [9:0] Y_INIT_V   = 10'(Y_INIT);
  localparam logic [9:0] X_MIN_V    = 10'(X_MIN);
  localparam logic [9:0] X_MAX_V    = 10'(X_MAX);
  localparam logic [9:0] Y_MIN_V    = 10'(Y_MIN);
  localparam logic [9:0] Y_GROUND_V = 10'(Y_GROUND);
  localparam logic [9:0] STEP_V     = 10'(STEP);
  localparam logic [3:0] JUMP_V_V   = 4'(JUMP_V);
  localparam logic [3:0] V_MAX_V    = 4'(V_MAX);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } state_t;

  // Synchroniser chains for the asynchronous key levels.
  logic left_s1, left_s2;
  logic right_s1, right_s2;
  logic jump_s1, jump_s2;

  // Frame tick generation.
  logic vs_d;
  logic tick_r;

  // Motion state.
  state_t     state, nx_state;
  logic [3:0] vel, nx_vel;
  logic [9:0] nx_x, nx_y;
  logic [3:0] fall_nv;
  logic [9:0] vel_w, fall_nv_w;

`ifdef PLAYER_DBLJUMP_EN
  logic jump_prev;
  logic dbl_used, nx_dbl;
  logic dbl_ok;
`endif

  // Two-flop synchronisers for the key inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_s1  <= 1'b0;
      left_s2  <= 1'b0;
      right_s1 <= 1'b0;
      right_s2 <= 1'b0;
      jump_s1  <= 1'b0;
      jump_s2  <= 1'b0;
    end else begin
      left_s1  <= key_left;
      left_s2  <= left_s1;
      right_s1 <= key_right;
      right_s2 <= right_s1;
      jump_s1  <= key_jump;
      jump_s2  <= jump_s1;
    end
  end

  // Registered one-cycle pulse on every falling edge of vsync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d   <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      vs_d   <= vsync;
      tick_r <= vs_d & ~vsync;
    end
  end

  assign vel_w     = {6'd0, vel};
  assign fall_nv   = (vel >= V_MAX_V) ? V_MAX_V : (vel + 4'd1);
  assign fall_nv_w = {6'd0, fall_nv};

`ifdef PLAYER_DBLJUMP_EN
  // A fresh press is one where the key is down now and was up at the previous tick.
  assign dbl_ok = jump_s2 & ~jump_prev & ~dbl_used;
`endif

  // Next-state logic: horizontal clamp-walk and the vertical jump FSM.
  always_comb begin
    nx_x     = pos_x;
    nx_y     = pos_y;
    nx_vel   = vel;
    nx_state = state;
`ifdef PLAYER_DBLJUMP_EN
    nx_dbl   = dbl_used;
`endif

    // The bound is compared before stepping, so the subtraction cannot underflow.
    if (left_s2 && !right_s2) begin
      nx_x = (pos_x <= X_MIN_V + STEP_V) ? X_MIN_V : (pos_x - STEP_V);
    end else if (right_s2 && !left_s2) begin
      nx_x = (pos_x + STEP_V >= X_MAX_V) ? X_MAX_V : (pos_x + STEP_V);
    end

    case (state)
      GROUND: begin
        if (jump_s2) begin
          nx_state = RISE;
          nx_vel   = JUMP_V_V;
        end
      end
      RISE: begin
        if (pos_y <= Y_MIN_V + vel_w) begin
          nx_y     = Y_MIN_V;
          nx_vel   = 4'd0;
          nx_state = FALL;
        end else begin
          nx_y   = pos_y - vel_w;
          nx_vel = vel - 4'd1;
          if (vel == 4'd1) nx_state = FALL;
        end
      end
      FALL: begin
        nx_vel = fall_nv;
        if (pos_y + fall_nv_w >= Y_GROUND_V) begin
          nx_y     = Y_GROUND_V;
          nx_vel   = 4'd0;
          nx_state = GROUND;
        end else begin
          nx_y = pos_y + fall_nv_w;
        end
      end
      default: begin
        nx_y     = Y_GROUND_V;
        nx_vel   = 4'd0;
        nx_state = GROUND;
      end
    endcase

`ifdef PLAYER_DBLJUMP_EN
    // The airborne re-jump overrides this tick's RISE/FALL step.
    if ((state == RISE || state == FALL) && dbl_ok) begin
      nx_y     = pos_y;
      nx_vel   = JUMP_V_V;
      nx_state = RISE;
      nx_dbl   = 1'b1;
    end
    if (nx_state == GROUND) nx_dbl = 1'b0;
`endif
  end

  // Commit position, velocity, state and frame count on each frame tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x     <= X_INIT_V;
      pos_y     <= Y_INIT_V;
      vel       <= 4'd0;
      state     <= GROUND;
      on_ground <= 1'b1;
      frame_cnt <= 16'd0;
    end else if (tick_r) begin
      pos_x     <= nx_x;
      pos_y     <= nx_y;
      vel       <= nx_vel;
      state     <= nx_state;
      on_ground <= (nx_state == GROUND);
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef PLAYER_DBLJUMP_EN
  // Double-jump bookkeeping: the key level at the previous tick, and whether the extra jump is spent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jump_prev <= 1'b0;
      dbl_used  <= 1'b0;
    end else if (tick_r) begin
      jump_prev <= jump_s2;
      dbl_used  <= nx_dbl;
    end
  end
`endif

endmodule
